sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl.sv | 115 +++++++++++
 tb/tb_sram_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Single-outstanding bus slave driving a 16-bit asynchronous SRAM.
// The access timing is fixed by the RD_CYCLES and WR_CYCLES parameters.
module sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned RD_CYCLES  = 2,
  parameter int unsigned WR_CYCLES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BE_WIDTH-1:0]   byteenable,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdataready,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);

  typedef enum logic [2:0] {IDLE, READ, WSETUP, WRITE, WREC} state_t;

  state_t     state;
  logic [3:0] cnt;

  // Busy whenever an access is in flight; reset blocks acceptance immediately.
  assign waitrequest = reset | (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      readdata      <= '0;
      readdataready <= 1'b0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_lb_n     <= 1'b1;
      sram_ub_n     <= 1'b1;
    end else begin
      readdataready <= 1'b0;
      case (state)
        IDLE: begin
          if (read || write) begin
            sram_addr   <= address;
            sram_dq_out <= writedata;
            sram_ce_n   <= 1'b0;
          end
          // A simultaneous read and write is serviced as a write.
          if (write) begin
            state      <= WSETUP;
            sram_dq_oe <= 1'b1;
            sram_lb_n  <= ~byteenable[0];
            sram_ub_n  <= ~byteenable[1];
          end else if (read) begin
            state     <= READ;
            cnt       <= 4'(RD_CYCLES - 1);
            sram_oe_n <= 1'b0;
            sram_lb_n <= 1'b0;
            sram_ub_n <= 1'b0;
          end
        end
        READ: begin
          if (cnt == 4'd0) begin
            state         <= IDLE;
            readdata      <= sram_dq_in;
            readdataready <= 1'b1;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_lb_n     <= 1'b1;
            sram_ub_n     <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WSETUP: begin
          state     <= WRITE;
          cnt       <= 4'(WR_CYCLES - 1);
          sram_we_n <= 1'b0;
        end
        WRITE: begin
          if (cnt == 4'd0) begin
            state     <= WREC;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WREC: begin
          // Address and data stay put through this cycle for SRAM hold time.
          state      <= IDLE;
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: board SRAM model, transaction-level reference model
// with a per-cycle compare process, and literal readback expectations.
module tb_sram_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int RD = 2;
  localparam int WR = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [BW-1:0] byteenable;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdataready;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  always #5 clock = ~clock;

  sram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
    .RD_CYCLES(RD), .WR_CYCLES(WR)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata), .readdataready(readdataready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Board SRAM: lanes written while CE and WE are low and the bus is driven.
  bit [DW-1:0] bmem [1024];
  always @(posedge clock) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) bmem[sram_addr[9:0]][7:0]  <= sram_dq_out[7:0];
      if (!sram_ub_n) bmem[sram_addr[9:0]][15:8] <= sram_dq_out[15:8];
    end
  end
  always_comb sram_dq_in = (!sram_ce_n && !sram_oe_n) ? bmem[sram_addr[9:0]] : 16'hDEAD;

  // Reference model: one transaction at a time, timed from its acceptance edge.
  bit [DW-1:0] ref_mem [1024];
  int          acc_e = -100;
  bit          acc_wr, active, prev_rdy;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data, exp_rd, last_rd;
  logic [BW-1:0] acc_be;
  int          rdy_at = -1;

  always @(negedge clock) begin : compare
    int ph;
    bit rd_act, wr_act, we_low, busy;
    logic lb_e, ub_e;
    if (reset) begin
      check("rst_waitrequest", waitrequest, 1);
      check("rst_readdataready", readdataready, 0);
      check("rst_readdata", readdata, 0);
      check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe}, 6'b111110);
      check("rst_sram_addr", sram_addr, 0);
      active   = 0;
      rdy_at   = -1;
      last_rd  = '0;
      prev_rdy = 0;
    end else begin
      ph     = cyc - acc_e;
      rd_act = active && !acc_wr && ph < RD;
      wr_act = active && acc_wr && ph < WR + 2;
      we_low = wr_act && ph >= 1 && ph <= WR;
      busy   = rd_act || wr_act;
      lb_e   = rd_act ? 1'b0 : (wr_act ? ~acc_be[0] : 1'b1);
      ub_e   = rd_act ? 1'b0 : (wr_act ? ~acc_be[1] : 1'b1);
      if (cyc == rdy_at) last_rd = exp_rd;
      check("readdataready", readdataready, cyc == rdy_at);
      check("readdata", readdata, last_rd);
      check("waitrequest", waitrequest, busy);
      check("strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe},
            {~busy, ~rd_act, ~we_low, lb_e, ub_e, wr_act});
      if (busy) check("sram_addr_stable", sram_addr, acc_addr);
      if (wr_act) check("sram_dq_out_stable", sram_dq_out, acc_data);
      check("oe_with_dq_oe", !sram_oe_n && sram_dq_oe, 0);
      check("oe_with_we", !sram_oe_n && !sram_we_n, 0);
      check("rdy_back_to_back", readdataready && prev_rdy, 0);
      prev_rdy = readdataready;
      if (!busy && (read || write)) begin
        active   = 1;
        acc_e    = cyc + 1;
        acc_wr   = write;
        acc_addr = address;
        acc_data = writedata;
        acc_be   = byteenable;
        if (write) begin
          if (byteenable[0]) ref_mem[address[9:0]][7:0]  = writedata[7:0];
          if (byteenable[1]) ref_mem[address[9:0]][15:8] = writedata[15:8];
        end else begin
          exp_rd = ref_mem[address[9:0]];
          rdy_at = acc_e + RD;
        end
      end
    end
  end

  // Presents a request from posedge+1 and returns just after its acceptance edge.
  task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BW-1:0] b);
    int n;
    read = rd; write = wr; address = a; writedata = d; byteenable = b;
    n = 0;
    @(negedge clock);
    while (waitrequest && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (waitrequest) check("accept_timeout", 1, 0);
    @(posedge clock);
    #1;
    read = 0; write = 0;
  endtask

  task automatic rd_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int k;
    bit seen;
    req(1, 0, a, 16'h0, 2'b00);
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      if (readdataready) seen = 1;
    end
    check("lit_read_latency", k, RD + 1);
    check("lit_readdata", readdata, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc_cyc [8];
    int n, r, g;
    reset = 1; read = 0; write = 0; address = '0; writedata = '0; byteenable = '0;
    repeat (3) @(posedge clock);
    #1 reset = 0;

    req(0, 1, 20'h00010, 16'hA5C3, 2'b11);
    rd_lit(20'h00010, 16'hA5C3);

    req(0, 1, 20'h00005, 16'h1234, 2'b11);
    req(0, 1, 20'h00005, 16'hFFFF, 2'b01);
    rd_lit(20'h00005, 16'h12FF);
    req(0, 1, 20'h00005, 16'h0000, 2'b00);
    rd_lit(20'h00005, 16'h12FF);

    for (int i = 0; i < 8; i++) req(0, 1, 20'(i), 16'(16'h1111 * i + 16'h0F0), 2'b11);

    // Read held high across eight addresses.
    read = 1; byteenable = 2'b00;
    for (int i = 0; i < 8; i++) begin
      address = 20'(i);
      n = 0;
      @(negedge clock);
      while (waitrequest && n < 20) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock);
      #1;
      acc_cyc[i] = cyc;
    end
    read = 0;
    for (int i = 1; i < 8; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], RD + 1);
    repeat (4) @(posedge clock);
    #1;

    // Read directly followed by a write to another address.
    req(1, 0, 20'h00003, 16'h0, 2'b00);
    req(0, 1, 20'h00009, 16'h3C3C, 2'b10);
    rd_lit(20'h00009, 16'h3C00);

    req(1, 1, 20'h00007, 16'hBEEF, 2'b11);
    rd_lit(20'h00007, 16'hBEEF);

    // Reset asserted during the first WE-low cycle.
    req(0, 1, 20'h003FF, 16'h5A5A, 2'b11);
    @(posedge clock);
    #3;
    check("we_low_before_reset", sram_we_n, 0);
    reset = 1;
    #1;
    check("async_rst_we_n", sram_we_n, 1);
    check("async_rst_ce_n", sram_ce_n, 1);
    check("async_rst_dq_oe", sram_dq_oe, 0);
    check("async_rst_waitrequest", waitrequest, 1);
    @(negedge clock);
    #1 reset = 0;
    @(negedge clock);
    check("post_rst_waitrequest", waitrequest, 0);
    check("post_rst_readdataready", readdataready, 0);
    @(posedge clock);
    #1;
    rd_lit(20'h00007, 16'hBEEF);

    for (int t = 0; t < 250; t++) begin
      r = int'($urandom_range(0, 3));
      req(r == 0 || r == 3, r != 0, 20'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
      g = int'($urandom_range(0, 2));
      repeat (g) begin
        @(posedge clock);
        #1;
      end
    end
    repeat (8) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
